serial_mag_comparator: RTL
==========================

Name: serial_mag_comparator

Overview:
Bit-serial magnitude comparator for two operand streams of arbitrary length, delivered MSB-first. Each beat carries one bit of A and one bit of B, and the block reports the word-level equal, greater and less result. It sits downstream of serialisers and lets wide operands be compared without a wide parallel comparator. Valid/ready handshake on both input and result sides.

Parameters:
MAX_BITS, 32, maximum supported word length in beats; longer words flag overflow.
CNT_W, $clog2(MAX_BITS+1), width of the beat counter; derived, do not override.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  beat on a_bit/b_bit/in_last is valid
in_ready  output  1  block accepts a beat this cycle
a_bit  input  1  current bit of operand A, MSB first
b_bit  input  1  current bit of operand B, MSB first
in_last  input  1  this beat is the LSB; closes the word
res_valid  output  1  result outputs are valid
res_ready  input  1  consumer accepts the result
e  output  1  A == B
g  output  1  A > B
l  output  1  A < B
bit_count  output  CNT_W  beats in the reported word, saturating at MAX_BITS
overflow  output  1  reported word exceeded MAX_BITS beats

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state IDLE; res_valid=0; e=g=l=0; bit_count=0; overflow=0; internal decided=0 and dir=0.
- in_ready = (state != HOLD). It decodes state only and has no combinational path from in_valid or res_ready.
- A beat is accepted when in_valid && in_ready.
- States:
  - IDLE: no word in progress. An accepted beat starts a word: clear decided, dir and overflow, set count=1, then go to COMPARE. If the beat has in_last, go directly to HOLD.
  - COMPARE: each accepted beat increments count, saturating at MAX_BITS. If count is already MAX_BITS when a beat is accepted, set overflow (sticky until the next word starts).
  - HOLD: in_ready=0. Outputs are stable until res_valid && res_ready. On that cycle, go to IDLE, and on the next edge clear res_valid and e/g/l.
- Decision rule, evaluated per accepted beat:
  - if !decided && a_bit != b_bit: set decided=1 and dir=a_bit (1 means A>B).
  - Later beats never change the decision (first differing bit from MSB wins).
- Result: on the edge that accepts the in_last beat, register:
  - e = !decided_next
  - g = decided_next && dir_next
  - l = decided_next && !dir_next
  - bit_count = count_next
  - overflow = overflow_next
  - res_valid = 1
  - decided_next, dir_next, count_next and overflow_next include the last beat itself.
- Latency: result is visible the cycle after the last beat is accepted.
- Throughput: at best one word every N+1 cycles for an N-beat word, because of the HOLD cycle.
- While res_valid=1, exactly one of e/g/l is 1. While res_valid=0, all three are 0.
- Single-beat word (first beat has in_last) is legal: 1-bit compare, bit_count=1.
- in_valid low mid-word: stall in COMPARE with state and count unchanged. No timeout.
- Overflow: comparison continues past MAX_BITS and the result is still correct by the first-difference rule. bit_count reports MAX_BITS; overflow=1.
- Reset mid-word or mid-HOLD: word is abandoned, all outputs return to their reset values, no partial result is emitted.
- a_bit, b_bit and in_last are ignored when the beat is not accepted.

Decomposition:
- Shared package (cmp_pkg):
  - state enum {IDLE, COMPARE, HOLD}
  - result encoding constants: RES_EQ=3'b100, RES_GT=3'b010, RES_LT=3'b001, in {e,g,l} order
- Sub-module: no separate sub-module. The saturating counter is small enough to keep inline.

Test Plan:
- 8-bit A=0xA5, B=0xA5, in_valid held high, res_ready=1 -> one cycle after last beat: res_valid=1, e=1, g=l=0, bit_count=8, overflow=0.
- A=0x80, B=0x7F -> decided at beat 0; g=1, bit_count=8. Repeat with bits after beat 0 randomised -> result unchanged.
- A=0x3C, B=0x3D -> decided only at last beat; l=1. A 1-beat word a=1, b=0 sent immediately after -> g=1, bit_count=1.
- Backpressure: hold res_ready=0 for 5 cycles with the next word's in_valid=1 -> in_ready=0 throughout; e/g/l/bit_count stable; the next word's first beat is accepted the cycle after the result handshake.
- MAX_BITS=4, 6-beat word A=101100, B=101010 -> g=1, bit_count=4, overflow=1. Following 3-beat word -> overflow=0.
- Assert rst_n low after 3 beats of an 8-beat word -> outputs clear asynchronously, no res_valid pulse. A fresh word after release compares correctly.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared types and result encodings for the bit-serial magnitude comparator.
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Result encodings in {e, g, l} order.
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_EQ   = 3'b100;
  localparam logic [2:0] RES_GT   = 3'b010;
  localparam logic [2:0] RES_LT   = 3'b001;

endpackage

// File: rtl/serial_mag_comparator.sv
// Bit-serial MSB-first magnitude comparator: the first differing bit decides the result,
// which is held with valid/ready until the consumer takes it.
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int MAX_BITS = 32,
  parameter int CNT_W    = $clog2(MAX_BITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a_bit,
  input  logic             b_bit,
  input  logic             in_last,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             e,
  output logic             g,
  output logic             l,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BITS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             decided_q, decided_d;
  logic             dir_q, dir_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             res_valid_q, res_valid_d;
  logic [2:0]       res_q, res_d;
  logic [CNT_W-1:0] bc_q, bc_d;
  logic             ovo_q, ovo_d;

  // Word state as it stands once the current beat is folded in.
  logic             dec_b, dir_b, ovf_b;
  logic [CNT_W-1:0] cnt_b;
  logic             accept;

  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    decided_d   = decided_q;
    dir_d       = dir_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_d       = res_q;
    bc_d        = bc_q;
    ovo_d       = ovo_q;

    // A beat taken in IDLE opens a fresh word; otherwise it extends the current one.
    if (state_q == IDLE) begin
      dec_b = 1'b0;
      dir_b = 1'b0;
      ovf_b = 1'b0;
      cnt_b = CNT_ONE;
    end else begin
      dec_b = decided_q;
      dir_b = dir_q;
      ovf_b = ovf_q || (cnt_q == CNT_MAX);
      cnt_b = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
    end
    if (!dec_b && (a_bit != b_bit)) begin
      dec_b = 1'b1;
      dir_b = a_bit;
    end

    if (accept) begin
      decided_d = dec_b;
      dir_d     = dir_b;
      ovf_d     = ovf_b;
      cnt_d     = cnt_b;
      if (in_last) begin
        state_d     = HOLD;
        res_valid_d = 1'b1;
        res_d       = !dec_b ? RES_EQ : (dir_b ? RES_GT : RES_LT);
        bc_d        = cnt_b;
        ovo_d       = ovf_b;
      end else begin
        state_d = COMPARE;
      end
    end else if (state_q == HOLD && res_ready) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
      res_d       = RES_NONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      decided_q   <= 1'b0;
      dir_q       <= 1'b0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_q       <= RES_NONE;
      bc_q        <= '0;
      ovo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      decided_q   <= decided_d;
      dir_q       <= dir_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_q       <= res_d;
      bc_q        <= bc_d;
      ovo_q       <= ovo_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign {e, g, l}   = res_q;
  assign bit_count   = bc_q;
  assign overflow    = ovo_q;

endmodule
